// File: rtl/sdram_sched_pkg.sv
// Shared definitions for the SDRAM burst scheduler.
//   grant_t : burst owner codes, also driven on the grant port
//   state_t : arbiter FSM encodings
//   DEF_*   : frame page geometry (one page = one full-page burst)
package sdram_sched_pkg;

    localparam int PAGE_WORDS      = 512;
    localparam int DEF_FRAME_PAGES = 600;
    localparam int DEF_SOBEL_BASE  = 600;
    localparam int ADDR_W          = 12;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_CAM  = 2'd1,
        GNT_VGA  = 2'd2,
        GNT_SOB  = 2'd3
    } grant_t;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_ACK  = 2'd2,
        ST_WAIT_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/page_addr_gen.sv
// Page address generator for one frame region.
//   clk, rst_n : clock, async active-low reset (addr returns to BASE)
//   adv        : step to the next page this cycle
//   addr       : current page, BASE .. BASE+PAGES-1
//   wrap       : high while adv is set on the last page
module page_addr_gen
    import sdram_sched_pkg::*;
#(
    parameter int BASE  = 0,
    parameter int PAGES = DEF_FRAME_PAGES
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              adv,
    output logic [ADDR_W-1:0] addr,
    output logic              wrap
);

    localparam logic [ADDR_W-1:0] FIRST = ADDR_W'(BASE);
    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(BASE + PAGES - 1);

    assign wrap = adv && (addr == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr <= FIRST;
        end else if (adv) begin
            addr <= (addr == LAST) ? FIRST : addr + 1'b1;
        end
    end

endmodule

// File: rtl/sdram_burst_arbiter.sv
// Full-page burst scheduler between camera write, Sobel write and VGA read.
//   clk, rst_n        : SDRAM clock, async active-low reset
//   ready             : controller idle / accepts a command
//   cam_count         : camera FIFO fill
//   sobel_count       : Sobel FIFO fill
//   vga_count         : VGA FIFO fill (write side)
//   sobel_mode        : 1 = display the Sobel frame
//   rw, rw_en, f_addr : controller command (1 = read), one-cycle strobe, page
//   grant             : burst owner, held until the burst completes
//   wr_src            : write data select, 1 = camera, 0 = Sobel
//   frame_wrap        : pulse when the camera page wraps to 0
//
// state        | meaning
// ST_IDLE      | evaluate requests, pick one winner when ready
// ST_ISSUE     | register the command for the winner, advance its page
// ST_WAIT_ACK  | wait for ready to drop; give up after ACK_TIMEOUT cycles
// ST_WAIT_DONE | burst running, leave when ready returns
module sdram_burst_arbiter
    import sdram_sched_pkg::*;
#(
    parameter int FRAME_PAGES = DEF_FRAME_PAGES,
    parameter int SOBEL_BASE  = DEF_SOBEL_BASE,
    parameter int WR_THRESH   = 512,
    parameter int RD_LOW      = 250,
    parameter int RD_CRIT     = 64,
    parameter int AGE_LIMIT   = 8,
    parameter int ACK_TIMEOUT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ready,
    input  logic [9:0]        cam_count,
    input  logic [9:0]        sobel_count,
    input  logic [9:0]        vga_count,
    input  logic              sobel_mode,
    output logic              rw,
    output logic              rw_en,
    output logic [ADDR_W-1:0] f_addr,
    output logic [1:0]        grant,
    output logic              wr_src,
    output logic              frame_wrap
);

    localparam logic [9:0]        WR_TH    = 10'(WR_THRESH);
    localparam logic [9:0]        RD_LO    = 10'(RD_LOW);
    localparam logic [9:0]        RD_CR    = 10'(RD_CRIT);
    localparam logic [3:0]        AGE_MAX  = 4'(AGE_LIMIT);
    localparam logic [2:0]        ACK_LOAD = 3'(ACK_TIMEOUT - 1);
    localparam logic [ADDR_W-1:0] RD_OFS   = ADDR_W'(SOBEL_BASE);

    state_t            state, state_nx;
    grant_t            win, pick;
    logic [3:0]        age;
    logic [2:0]        ack_tmr;
    logic              disp_sel;
    logic              cam_req, vga_req, vga_crit, sob_req;
    logic              adv_cam, adv_sob, adv_rd;
    logic              cam_wrap, rd_wrap, sob_wrap_unused;
    logic [ADDR_W-1:0] cam_addr, sob_addr, rd_addr;

    page_addr_gen #(.BASE(0), .PAGES(FRAME_PAGES)) u_cam_addr (
        .clk(clk), .rst_n(rst_n), .adv(adv_cam), .addr(cam_addr), .wrap(cam_wrap)
    );
    page_addr_gen #(.BASE(SOBEL_BASE), .PAGES(FRAME_PAGES)) u_sob_addr (
        .clk(clk), .rst_n(rst_n), .adv(adv_sob), .addr(sob_addr), .wrap(sob_wrap_unused)
    );
    page_addr_gen #(.BASE(0), .PAGES(FRAME_PAGES)) u_rd_addr (
        .clk(clk), .rst_n(rst_n), .adv(adv_rd), .addr(rd_addr), .wrap(rd_wrap)
    );

    always_comb begin
        cam_req  = cam_count > WR_TH;
        sob_req  = sobel_count > WR_TH;
        vga_req  = vga_count < RD_LO;
        vga_crit = vga_count < RD_CR;

        pick = GNT_NONE;
        if (vga_crit)                       pick = GNT_VGA;
        else if (sob_req && age == AGE_MAX) pick = GNT_SOB;
        else if (cam_req)                   pick = GNT_CAM;
        else if (vga_req)                   pick = GNT_VGA;
        else if (sob_req)                   pick = GNT_SOB;
    end

    always_comb begin
        state_nx = state;
        adv_cam  = 1'b0;
        adv_sob  = 1'b0;
        adv_rd   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (ready && pick != GNT_NONE) state_nx = ST_ISSUE;
            end
            ST_ISSUE: begin
                state_nx = ST_WAIT_ACK;
                adv_cam  = (win == GNT_CAM);
                adv_sob  = (win == GNT_SOB);
                adv_rd   = (win == GNT_VGA);
            end
            ST_WAIT_ACK: begin
                if (!ready)              state_nx = ST_WAIT_DONE;
                else if (ack_tmr == '0)  state_nx = ST_IDLE;
            end
            ST_WAIT_DONE: begin
                if (ready) state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            win        <= GNT_NONE;
            age        <= '0;
            ack_tmr    <= '0;
            disp_sel   <= 1'b0;
            rw         <= 1'b0;
            rw_en      <= 1'b0;
            f_addr     <= '0;
            grant      <= GNT_NONE;
            wr_src     <= 1'b1;
            frame_wrap <= 1'b0;
        end else begin
            state      <= state_nx;
            rw_en      <= (state == ST_ISSUE);
            frame_wrap <= cam_wrap;

            if (state == ST_IDLE) begin
                if (!sob_req) begin
                    age <= '0;
                end else if (state_nx == ST_ISSUE) begin
                    if (pick == GNT_SOB)     age <= '0;
                    else if (age != AGE_MAX) age <= age + 1'b1;
                end
                if (state_nx == ST_ISSUE) win <= pick;
            end

            if (state == ST_ISSUE) begin
                rw      <= (win == GNT_VGA);
                grant   <= win;
                ack_tmr <= ACK_LOAD;
                if (win != GNT_VGA) wr_src <= (win == GNT_CAM);
                case (win)
                    GNT_CAM: f_addr <= cam_addr;
                    GNT_SOB: f_addr <= sob_addr;
                    GNT_VGA: f_addr <= rd_addr + (disp_sel ? RD_OFS : '0);
                    default: f_addr <= '0;
                endcase
            end

            if (state == ST_WAIT_ACK && ready && ack_tmr != '0) ack_tmr <= ack_tmr - 1'b1;

            if (state != ST_IDLE && state_nx == ST_IDLE) grant <= GNT_NONE;

            // Display frame switches only at a frame boundary to avoid tearing.
            if (rd_wrap || (state == ST_IDLE && rd_addr == '0)) disp_sel <= sobel_mode;
        end
    end

endmodule

// File: tb/tb_sdram_burst_arbiter.sv
module tb_sdram_burst_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ready = 1'b1;
    logic        sobel_mode = 1'b0;
    logic [9:0]  cam_count = 10'd0;
    logic [9:0]  sobel_count = 10'd0;
    logic [9:0]  vga_count = 10'd300;
    logic        rw, rw_en, wr_src, frame_wrap;
    logic [11:0] f_addr;
    logic [1:0]  grant;

    sdram_burst_arbiter dut (
        .clk(clk), .rst_n(rst_n), .ready(ready),
        .cam_count(cam_count), .sobel_count(sobel_count), .vga_count(vga_count),
        .sobel_mode(sobel_mode),
        .rw(rw), .rw_en(rw_en), .f_addr(f_addr), .grant(grant),
        .wr_src(wr_src), .frame_wrap(frame_wrap)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        rw;
        logic [11:0] addr;
        logic [1:0]  gnt;
        logic        src;
        logic        wrap;
    } cmd_t;

    cmd_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   wrap_seen = 0;
    int   nwait;
    int   cnt;
    int   m_cam = 0;
    int   m_sob = 600;
    int   m_rd = 0;
    bit   m_src = 1'b1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic push_cam();
        exp_q.push_back('{1'b0, 12'(m_cam), 2'd1, 1'b1, (m_cam == 599)});
        m_cam = (m_cam == 599) ? 0 : m_cam + 1;
        m_src = 1'b1;
    endtask

    task automatic push_sob();
        exp_q.push_back('{1'b0, 12'(m_sob), 2'd3, 1'b0, 1'b0});
        m_sob = (m_sob == 1199) ? 600 : m_sob + 1;
        m_src = 1'b0;
    endtask

    task automatic push_vga(input bit sel);
        exp_q.push_back('{1'b1, 12'(m_rd + (sel ? 600 : 0)), 2'd2, m_src, 1'b0});
        m_rd = (m_rd == 599) ? 0 : m_rd + 1;
    endtask

    // mode 0: controller drops ready for one cycle; 1: ready stays high;
    // 2: ready dropped and left low (burst in progress on return)
    task automatic do_burst(input int mode, output int n);
        cmd_t e;
        bit   seen;
        seen = 1'b0;
        n = 0;
        while (!seen && n < 30) begin
            @(negedge clk);
            n++;
            if (frame_wrap) wrap_seen++;
            if (rw_en) seen = 1'b1;
        end
        check("rw_en_arrival", 32'(seen), 32'd1);
        if (!seen) return;
        check("queue_nonempty", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() == 0) return;
        e = exp_q.pop_front();
        check("rw", 32'(rw), 32'(e.rw));
        check("f_addr", 32'(f_addr), 32'(e.addr));
        check("grant", 32'(grant), 32'(e.gnt));
        check("wr_src", 32'(wr_src), 32'(e.src));
        check("frame_wrap", 32'(frame_wrap), 32'(e.wrap));
        if (mode == 0) begin
            ready = 1'b0;
            @(negedge clk);
            ready = 1'b1;
        end else if (mode == 2) begin
            ready = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rw"}, 32'(rw), 32'd0);
        check({tag, "_rw_en"}, 32'(rw_en), 32'd0);
        check({tag, "_f_addr"}, 32'(f_addr), 32'd0);
        check({tag, "_grant"}, 32'(grant), 32'd0);
        check({tag, "_wr_src"}, 32'(wr_src), 32'd1);
        check({tag, "_frame_wrap"}, 32'(frame_wrap), 32'd0);
    endtask

    initial begin
        // reset state
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");

        // single camera burst: latency 2 edges, grant cleared after completion
        rst_n = 1'b1;
        cam_count = 10'd513;
        push_cam();
        do_burst(0, nwait);
        check("first_latency", 32'(nwait), 32'd2);
        cam_count = 10'd0;
        @(negedge clk);
        check("grant_after_done", 32'(grant), 32'd0);
        check("wr_src_hold", 32'(wr_src), 32'd1);
        cam_count = 10'd513;
        push_cam();
        do_burst(0, nwait);
        cam_count = 10'd0;

        // simultaneous camera / VGA / Sobel requests
        cam_count = 10'd600;
        vga_count = 10'd100;
        sobel_count = 10'd600;
        push_cam();
        push_vga(1'b0);
        push_sob();
        do_burst(0, nwait);
        cam_count = 10'd0;
        do_burst(0, nwait);
        vga_count = 10'd300;
        do_burst(0, nwait);
        sobel_count = 10'd0;

        // critical VGA beats camera
        cam_count = 10'd600;
        vga_count = 10'd30;
        push_vga(1'b0);
        push_cam();
        do_burst(0, nwait);
        vga_count = 10'd300;
        do_burst(0, nwait);
        cam_count = 10'd0;

        // Sobel ageing under continuous camera load
        cam_count = 10'd600;
        sobel_count = 10'd600;
        for (int i = 0; i < 18; i++) begin
            if (i == 8 || i == 17) push_sob();
            else                   push_cam();
            do_burst(0, nwait);
        end
        cam_count = 10'd0;
        sobel_count = 10'd0;

        // camera frame wrap
        wrap_seen = 0;
        cam_count = 10'd600;
        cnt = 600 - m_cam + 1;
        for (int i = 0; i < cnt; i++) begin
            push_cam();
            do_burst(0, nwait);
        end
        cam_count = 10'd0;
        check("frame_wrap_count", 32'(wrap_seen), 32'd1);

        // Sobel frame wrap
        sobel_count = 10'd600;
        cnt = 1200 - m_sob + 1;
        for (int i = 0; i < cnt; i++) begin
            push_sob();
            do_burst(0, nwait);
        end
        sobel_count = 10'd0;

        // display switch waits for the read frame boundary
        vga_count = 10'd100;
        while (m_rd < 300) begin
            push_vga(1'b0);
            do_burst(0, nwait);
        end
        sobel_mode = 1'b1;
        while (m_rd != 0) begin
            push_vga(1'b0);
            do_burst(0, nwait);
        end
        push_vga(1'b1);
        do_burst(0, nwait);
        push_vga(1'b1);
        do_burst(0, nwait);
        vga_count = 10'd300;

        // ack timeout: ready never drops, next issue after 4 wait cycles
        cam_count = 10'd600;
        push_cam();
        do_burst(1, nwait);
        push_cam();
        do_burst(0, nwait);
        check("timeout_spacing", 32'(nwait), 32'd6);

        // async reset during a running burst
        push_cam();
        do_burst(2, nwait);
        check("grant_in_burst", 32'(grant), 32'd1);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("async_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sdram_burst_arbiter.md
Name: sdram_burst_arbiter

Overview:
Schedules full-page (512-word) SDRAM bursts between three requesters: camera-FIFO write, Sobel-result write and VGA-FIFO refill read.
- Sits between the requester FIFO fill counts and the SDRAM controller command port (rw, rw_en, f_addr, ready).
- Owns the page-address generators for the colour frame, the Sobel frame and the display read pointer.
- Holds the write-source select that steers f2s data and FIFO read strobes during a burst.

Parameters:
- FRAME_PAGES, 600: pages per 640x480 frame.
- SOBEL_BASE, 600: first page of the Sobel frame region.
- WR_THRESH, 512: write request when fill count > WR_THRESH.
- RD_LOW, 250: read request when VGA fill count < RD_LOW.
- RD_CRIT, 64: VGA urgent when fill count < RD_CRIT.
- AGE_LIMIT, 8: consecutive lost arbitrations before Sobel is promoted.
- ACK_TIMEOUT, 4: cycles to wait for ready to drop after issue.

Ports:
- clk, in, 1: SDRAM clock, 143 MHz.
- rst_n, in, 1: asynchronous active-low reset.
- ready, in, 1: controller idle / accepts command.
- cam_count, in, 10: camera FIFO fill.
- sobel_count, in, 10: Sobel FIFO fill.
- vga_count, in, 10: VGA FIFO fill (write-side count).
- sobel_mode, in, 1: 1 = display Sobel frame.
- rw, out, 1: 1 = read, 0 = write.
- rw_en, out, 1: one-cycle command strobe.
- f_addr, out, 12: page address.
- grant, out, 2: 0 none, 1 camera, 2 VGA, 3 Sobel; held for the burst.
- wr_src, out, 1: 1 = camera data, 0 = Sobel data; changes only on a write issue.
- frame_wrap, out, 1: one-cycle pulse when the camera address wraps to 0.

Behaviour:
- Reset (async, rst_n=0): rw=0, rw_en=0, f_addr=0, grant=0, wr_src=1, frame_wrap=0.
- Reset internals: cam_addr=0, rd_addr=0, sob_addr=SOBEL_BASE, age=0, disp_sel=0, state=IDLE.
- Reset mid-burst aborts immediately; the controller is reset by the same rst_n.
- All outputs are registered.
- Requests, evaluated in IDLE only: cam_req = cam_count>WR_THRESH; vga_req = vga_count<RD_LOW; vga_crit = vga_count<RD_CRIT; sob_req = sobel_count>WR_THRESH.
- Priority, highest first:
  - vga_crit
  - sob_req when age==AGE_LIMIT
  - cam_req
  - vga_req
  - sob_req
- Age counter:
  - Increments (saturating at AGE_LIMIT) on each grant issued while sob_req=1 and Sobel is not granted.
  - Clears on a Sobel grant, and when sob_req=0 in IDLE.
- FSM:
  - IDLE: if ready=1 and any request, go to ISSUE; else stay; grant=0.
  - ISSUE, one cycle: rw_en=1, rw and f_addr driven, grant set, wr_src updated on writes; advance the winner's address; then WAIT_ACK.
  - WAIT_ACK: rw_en=0; on ready=0 go to WAIT_DONE. If ready stays 1 for ACK_TIMEOUT cycles, go to IDLE (command assumed accepted, address not rolled back).
  - WAIT_DONE: on ready=1 go to IDLE; grant returns to 0 on that transition; wr_src holds.
- Latency: request true with ready=1 in IDLE gives rw_en at 2 clk edges; minimum spacing between rw_en pulses is 4 cycles.
- Addressing:
  - Camera write: f_addr=cam_addr; next = (cam_addr==FRAME_PAGES-1) ? 0 : cam_addr+1. frame_wrap pulses in the ISSUE cycle that wraps.
  - Sobel write: f_addr=sob_addr; wraps from SOBEL_BASE+FRAME_PAGES-1 to SOBEL_BASE.
  - VGA read: f_addr = rd_addr + (disp_sel ? SOBEL_BASE : 0); rd_addr wraps at FRAME_PAGES-1 to 0.
  - disp_sel loads sobel_mode only when rd_addr wraps, or while rd_addr==0 in IDLE, so there is no mid-frame tearing.
- Width: f_addr sums are 12-bit; the maximum 1199 fits.
- Simultaneous requests resolve strictly by the priority list, with a single grant per IDLE pass.
- Request changes after ISSUE are ignored until IDLE.
- ready=0 in IDLE gives no issue.

Decomposition:
- Shared package sdram_sched_pkg holds:
  - grant codes (GNT_NONE/CAM/VGA/SOB)
  - FSM state encodings
  - page-geometry constants (FRAME_PAGES, SOBEL_BASE, page size 512)
- Natural sub-module page_addr_gen, instantiated three times with params BASE/PAGES:
  - inputs: clk, rst_n, adv
  - outputs: addr, wrap

Test Plan:
- Reset then cam_count=513, ready=1 -> rw_en at cycle 2, rw=0, f_addr=0, grant=1, wr_src=1; after ready 0→1, grant=0; next camera burst uses f_addr=1.
- cam_count=600, vga_count=100, sobel_count=600 simultaneously -> order camera, VGA, Sobel (rw 0,1,0; f_addr 0,0,600). With vga_count=30 (below RD_CRIT), VGA is granted first.
- cam_count and sobel_count held >512 continuously -> after 8 camera grants, the 9th grant is Sobel (f_addr=600) and age clears.
- Drive 600 camera bursts -> f_addr sequence 0..599 then 0; frame_wrap pulses exactly once, on the issue with f_addr=599. Sobel likewise runs 600..1199 then 600.
- sobel_mode set to 1 at rd_addr=300 -> reads continue at 300..599 unchanged; after the wrap, reads issue at 600, 601, ...
- Controller holds ready=1 after rw_en -> return to IDLE after 4 cycles, next issue uses advanced address. Assert rst_n=0 during WAIT_DONE -> all outputs are at reset values immediately, without waiting for a clock edge.
